// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds the step encoding, opcode constants, IR field positions, the
// opcode-class decoder and the packed bundle of registered control strobes.
package cu_pkg;

    localparam int NREGS = 16;
    localparam int OPW   = 5;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // Instructions grouped by the shape of their execute sequence
    typedef enum logic [2:0] {
        CLS_THREE,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } opclass_t;

    function automatic opclass_t classifyOp(input logic [OPW-1:0] op);
        opclass_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls = CLS_THREE;
            OP_MUL, OP_DIV:                   cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                   cls = CLS_UNARY;
            OP_NOP:                           cls = CLS_NOP;
            OP_HALT:                          cls = CLS_HALT;
            default:                          cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Register-select requests (gra/grb/grc with rIn/rOut) are kept here
    // and expanded to one-hot vectors downstream of the register.
    typedef struct packed {
        logic           pcOut;
        logic           zHighOut;
        logic           zLowOut;
        logic           mdrOut;
        logic           hiOut;
        logic           loOut;
        logic           marIn;
        logic           pcIn;
        logic           mdrIn;
        logic           irIn;
        logic           yIn;
        logic           incPc;
        logic           read;
        logic           hiIn;
        logic           loIn;
        logic           zHighIn;
        logic           zLowIn;
        logic           cIn;
        logic           gra;
        logic           grb;
        logic           grc;
        logic           rIn;
        logic           rOut;
        logic [OPW-1:0] opcode;
        logic           run;
        logic           illegal;
    } ctrl_t;

endpackage

// File: rtl/select_encode.sv
// Register select encoder.
// Picks ra, rb or rc (priority gra > grb > grc) and expands it into one-hot
// register load and register drive vectors. Purely combinational.
// Ports:
//   ra_i, rb_i, rc_i       : 4-bit register fields from the latched IR
//   gra_i, grb_i, grc_i    : field select requests
//   rIn_i, rOut_i          : enable the load vector / drive vector
//   rinVec_o, routVec_o    : one-hot R0..R15 load / drive strobes, or zero
module select_encode
    import cu_pkg::*;
(
    input  logic [3:0]       ra_i,
    input  logic [3:0]       rb_i,
    input  logic [3:0]       rc_i,
    input  logic             gra_i,
    input  logic             grb_i,
    input  logic             grc_i,
    input  logic             rIn_i,
    input  logic             rOut_i,
    output logic [NREGS-1:0] rinVec_o,
    output logic [NREGS-1:0] routVec_o
);

    logic [3:0]       regSel;
    logic [NREGS-1:0] decoded;

    // With no field requested the decode stays zero so neither vector can
    // accidentally strobe R0.
    always_comb begin
        regSel  = 4'd0;
        decoded = '0;
        if (gra_i) begin
            regSel = ra_i;
        end else if (grb_i) begin
            regSel = rb_i;
        end else if (grc_i) begin
            regSel = rc_i;
        end
        if (gra_i || grb_i || grc_i) begin
            decoded[regSel] = 1'b1;
        end
        rinVec_o  = rIn_i  ? decoded : '0;
        routVec_o = rOut_i ? decoded : '0;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer driving DataPath.
// Steps through fetch (T0-T2) and execute (T3-T6) and emits one registered
// set of strobes per step. Outputs depend only on the step register and the
// IR latched at the end of T2.
// Ports:
//   clock, clear (async, active-low)
//   ir        : IR contents fed back from DataPath
//   mem_ready : memory read data valid, ends the T1 wait
//   stop      : halt at the next instruction boundary
//   bus-out strobes, load strobes, Read, Rin_vec/Rout_vec (one-hot),
//   opcode (ALU op), run (not halted/reset), illegal (T3 pulse)
module control_sequencer
    import cu_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             HIout,
    output logic             LOout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             HIin,
    output logic             LOin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             Cin,
    output logic [NREGS-1:0] Rin_vec,
    output logic [NREGS-1:0] Rout_vec,
    output logic [OPW-1:0]   opcode,
    output logic             run,
    output logic             illegal
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    opclass_t    curClass, nextClass;
    logic        unusedIrBits;

    assign unusedIrBits = ^ir_q[IR_RC_LO-1:0];

    // Step sequencing. The IR is captured on the T2 exit so every execute
    // step decodes from a stable copy. The last execute step of each class
    // is where stop diverts to HALT.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        curClass = classifyOp(ir_q[IR_OP_HI:IR_OP_LO]);
        unique case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2: begin
                state_d = ST_T3;
                ir_d    = ir;
            end
            ST_T3: begin
                if (curClass == CLS_HALT) begin
                    state_d = ST_HALT;
                end else if (curClass == CLS_NOP || curClass == CLS_ILLEGAL) begin
                    state_d = stop ? ST_HALT : ST_T0;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4: begin
                if (curClass == CLS_UNARY) begin
                    state_d = stop ? ST_HALT : ST_T0;
                end else begin
                    state_d = ST_T5;
                end
            end
            ST_T5: begin
                if (curClass == CLS_MULDIV) begin
                    state_d = ST_T6;
                end else begin
                    state_d = stop ? ST_HALT : ST_T0;
                end
            end
            ST_T6:   state_d = stop ? ST_HALT : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Strobes for the step being entered, so the registered outputs line up
    // exactly with the state register.
    always_comb begin
        ctrl_d     = '0;
        nextClass  = classifyOp(ir_d[IR_OP_HI:IR_OP_LO]);
        ctrl_d.run = (state_d != ST_RST) && (state_d != ST_HALT);
        case (state_d)
            ST_T0: begin
                ctrl_d.pcOut  = 1'b1;
                ctrl_d.marIn  = 1'b1;
                ctrl_d.incPc  = 1'b1;
                ctrl_d.zLowIn = 1'b1;
            end
            ST_T1: begin
                ctrl_d.zLowOut = 1'b1;
                ctrl_d.pcIn    = 1'b1;
                ctrl_d.read    = 1'b1;
                ctrl_d.mdrIn   = 1'b1;
            end
            ST_T2: begin
                ctrl_d.mdrOut = 1'b1;
                ctrl_d.irIn   = 1'b1;
            end
            ST_T3: begin
                if (nextClass == CLS_THREE || nextClass == CLS_MULDIV) begin
                    ctrl_d.grc  = 1'b1;
                    ctrl_d.rOut = 1'b1;
                    ctrl_d.yIn  = 1'b1;
                end else if (nextClass == CLS_UNARY) begin
                    ctrl_d.grb    = 1'b1;
                    ctrl_d.rOut   = 1'b1;
                    ctrl_d.opcode = ir_d[IR_OP_HI:IR_OP_LO];
                    ctrl_d.zLowIn = 1'b1;
                end else if (nextClass == CLS_ILLEGAL) begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            ST_T4: begin
                if (nextClass == CLS_UNARY) begin
                    ctrl_d.zLowOut = 1'b1;
                    ctrl_d.gra     = 1'b1;
                    ctrl_d.rIn     = 1'b1;
                end else begin
                    ctrl_d.grb     = 1'b1;
                    ctrl_d.rOut    = 1'b1;
                    ctrl_d.opcode  = ir_d[IR_OP_HI:IR_OP_LO];
                    ctrl_d.zLowIn  = 1'b1;
                    ctrl_d.zHighIn = 1'b1;
                end
            end
            ST_T5: begin
                ctrl_d.zLowOut = 1'b1;
                if (nextClass == CLS_MULDIV) begin
                    ctrl_d.loIn = 1'b1;
                end else begin
                    ctrl_d.gra = 1'b1;
                    ctrl_d.rIn = 1'b1;
                end
            end
            ST_T6: begin
                ctrl_d.zHighOut = 1'b1;
                ctrl_d.hiIn     = 1'b1;
            end
            default: ;
        endcase
    end

    // State, IR copy and output register; clear drops every strobe at once.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RST;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    select_encode u_selectEncode (
        .ra_i      (ir_q[IR_RA_HI:IR_RA_LO]),
        .rb_i      (ir_q[IR_RB_HI:IR_RB_LO]),
        .rc_i      (ir_q[IR_RC_HI:IR_RC_LO]),
        .gra_i     (ctrl_q.gra),
        .grb_i     (ctrl_q.grb),
        .grc_i     (ctrl_q.grc),
        .rIn_i     (ctrl_q.rIn),
        .rOut_i    (ctrl_q.rOut),
        .rinVec_o  (Rin_vec),
        .routVec_o (Rout_vec)
    );

    assign PCout    = ctrl_q.pcOut;
    assign Zhighout = ctrl_q.zHighOut;
    assign Zlowout  = ctrl_q.zLowOut;
    assign MDRout   = ctrl_q.mdrOut;
    assign HIout    = ctrl_q.hiOut;
    assign LOout    = ctrl_q.loOut;
    assign MARin    = ctrl_q.marIn;
    assign PCin     = ctrl_q.pcIn;
    assign MDRin    = ctrl_q.mdrIn;
    assign IRin     = ctrl_q.irIn;
    assign Yin      = ctrl_q.yIn;
    assign IncPC    = ctrl_q.incPc;
    assign Read     = ctrl_q.read;
    assign HIin     = ctrl_q.hiIn;
    assign LOin     = ctrl_q.loIn;
    assign ZHighIn  = ctrl_q.zHighIn;
    assign ZLowIn   = ctrl_q.zLowIn;
    assign Cin      = ctrl_q.cIn;
    assign opcode   = ctrl_q.opcode;
    assign run      = ctrl_q.run;
    assign illegal  = ctrl_q.illegal;

endmodule
